// File: rtl/cpu_exec_core.sv
// cpu_exec_core: 8-bit execution core (ALU, PC, SP, microcycle sequencer); ports clk/reset, opcode/bus_in/rega/regb in; state/cycle/pc/sp/alu_out/flags out
module cpu_exec_core (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic [7:0] bus_in,
  input  logic [7:0] rega,
  input  logic [7:0] regb,
  output logic [4:0] state,
  output logic [3:0] cycle,
  output logic [7:0] pc,
  output logic [7:0] sp,
  output logic [7:0] alu_out,
  output logic       eq_zero,
  output logic       alu_equal,
  output logic       jump_allowed,
  output logic       halted
);
  typedef enum logic [4:0] {
    FETCH_PC, FETCH_INST, NEXT, HALT, OUT_A, ALU_OP, JUMP, LDI, MOV_FETCH, MOV_LOAD,
    MOV_STORE, FETCH_SP, PC_STORE, TMP_STORE, TMP_JUMP, RET, INC_SP
  } state_t;
  state_t st, st_n;
  logic [2:0] mode;
  logic is_hlt, is_out, is_call, is_ret, is_ldi, is_mov, is_alu, is_jmp, mov_mem, pc_ld, pc_inc;
  assign is_hlt = opcode == 8'h01;
  assign is_out = opcode == 8'h02;
  assign is_call = opcode == 8'h03;
  assign is_ret = opcode == 8'h04;
  assign is_ldi = opcode[7:3] == 5'b00001;
  assign is_mov = opcode[7:6] == 2'b01;
  assign is_alu = opcode[7:6] == 2'b10;
  assign is_jmp = opcode[7:6] == 2'b11;
  assign mov_mem = opcode[5:3] == 3'd7 || opcode[2:0] == 3'd7;
  assign state = st;
  assign halted = st == HALT;
  assign mode = st == ALU_OP ? opcode[5:3] : 3'd0;
  assign eq_zero = alu_out == 8'h00;
  assign alu_equal = rega == regb;
  assign jump_allowed = opcode[2:0] == 3'd0 ? 1'b1 :
                        opcode[2:0] == 3'd1 ? eq_zero :
                        opcode[2:0] == 3'd2 ? !eq_zero :
                        opcode[2:0] == 3'd3 ? alu_equal :
                        opcode[2:0] == 3'd4 ? !alu_equal : 1'b0;
  assign pc_ld = (st == JUMP && jump_allowed) || st == RET || st == TMP_JUMP;
  assign pc_inc = st == FETCH_INST || st == LDI || st == TMP_STORE || st == JUMP || (st == MOV_LOAD && mov_mem);
  always_comb begin
    alu_out = 8'h00;
    case (mode)
      3'd0: alu_out = rega + regb;
      3'd1: alu_out = rega - regb;
      3'd2: alu_out = rega + 8'd1;
      3'd3: alu_out = rega - 8'd1;
      3'd4: alu_out = rega & regb;
      3'd5: alu_out = rega | regb;
      3'd6: alu_out = rega ^ regb;
      default: alu_out = ~rega;
    endcase
  end
  always_comb begin
    st_n = NEXT;
    case (st)
      FETCH_PC: st_n = cycle == 4'd0 ? FETCH_INST : is_call ? TMP_STORE : is_ldi ? LDI : JUMP;
      FETCH_INST: st_n = is_hlt ? HALT : is_out ? OUT_A : (is_call || is_ldi || is_jmp) ? FETCH_PC :
                         is_ret ? INC_SP : is_mov ? MOV_FETCH : is_alu ? ALU_OP : NEXT;
      NEXT: st_n = FETCH_PC;
      HALT: st_n = HALT;
      MOV_FETCH: st_n = MOV_LOAD;
      MOV_LOAD: st_n = MOV_STORE;
      TMP_STORE: st_n = FETCH_SP;
      FETCH_SP: st_n = is_call ? PC_STORE : RET;
      PC_STORE: st_n = TMP_JUMP;
      INC_SP: st_n = FETCH_SP;
      default: st_n = NEXT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= FETCH_PC;
      cycle <= 4'd0;
      pc <= 8'h00;
      sp <= 8'hFF;
    end else begin
      st <= st_n;
      cycle <= st == NEXT ? 4'd0 : st == HALT ? cycle : cycle + 4'd1;
      pc <= pc_ld ? bus_in : pc_inc ? pc + 8'd1 : pc;
      sp <= st == TMP_JUMP ? sp - 8'd1 : st == INC_SP ? sp + 8'd1 : sp;
    end
  end
endmodule

// File: tb/tb_cpu_exec_core.sv
// tb_cpu_exec_core: directed and randomized checks of cpu_exec_core against an instruction-level model
module tb_cpu_exec_core;
  logic clk = 0, reset = 1;
  logic [7:0] opcode = 8'h00, bus_in = 8'h00, rega = 8'h00, regb = 8'h00;
  logic [4:0] state;
  logic [3:0] cycle;
  logic [7:0] pc, sp, alu_out;
  logic eq_zero, alu_equal, jump_allowed, halted;
  int checks = 0, passes = 0;
  bit chk_on = 0;
  typedef logic [4:0] seq_t [8];
  seq_t m_seq;
  int m_idx;
  logic [7:0] m_pc, m_sp;

  cpu_exec_core dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bus_in(bus_in), .rega(rega), .regb(regb),
    .state(state), .cycle(cycle), .pc(pc), .sp(sp), .alu_out(alu_out), .eq_zero(eq_zero),
    .alu_equal(alu_equal), .jump_allowed(jump_allowed), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a + 8'd1;
      3'd3: return a - 8'd1;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic bit jok(input logic [2:0] c, input bit z, input bit e);
    return c == 0 || (c == 1 && z) || (c == 2 && !z) || (c == 3 && e) || (c == 4 && !e);
  endfunction

  function automatic seq_t build(input logic [7:0] op);
    seq_t s;
    s = '{default: 5'd2};
    s[0] = 5'd0;
    s[1] = 5'd1;
    if (op == 8'h01) s[2] = 5'd3;
    else if (op == 8'h02) s[2] = 5'd4;
    else if (op == 8'h03) begin
      s[2] = 5'd0; s[3] = 5'd13; s[4] = 5'd11; s[5] = 5'd12; s[6] = 5'd14;
    end else if (op == 8'h04) begin
      s[2] = 5'd16; s[3] = 5'd11; s[4] = 5'd15;
    end else if (op[7:3] == 5'b00001) begin
      s[2] = 5'd0; s[3] = 5'd7;
    end else if (op[7:6] == 2'b01) begin
      s[2] = 5'd8; s[3] = 5'd9; s[4] = 5'd10;
    end else if (op[7:6] == 2'b10) s[2] = 5'd5;
    else if (op[7:6] == 2'b11) begin
      s[2] = 5'd0; s[3] = 5'd6;
    end
    return s;
  endfunction

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h want %h at %0t", n, got, exp, $time);
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk or posedge reset) begin : model
    logic [4:0] cur;
    logic [7:0] a;
    if (reset) begin
      m_seq <= build(8'h00);
      m_idx <= 0;
      m_pc <= 8'h00;
      m_sp <= 8'hFF;
    end else begin
      cur = m_seq[m_idx];
      a = alu_f(cur == 5'd5 ? opcode[5:3] : 3'd0, rega, regb);
      if ((cur == 5'd6 && jok(opcode[2:0], a == 0, rega == regb)) || cur == 5'd15 || cur == 5'd14) m_pc <= bus_in;
      else if (cur == 5'd1 || cur == 5'd7 || cur == 5'd13 || cur == 5'd6 ||
               (cur == 5'd9 && (opcode[5:3] == 3'd7 || opcode[2:0] == 3'd7))) m_pc <= m_pc + 8'd1;
      if (cur == 5'd14) m_sp <= m_sp - 8'd1;
      else if (cur == 5'd16) m_sp <= m_sp + 8'd1;
      if (cur == 5'd1) m_seq <= build(opcode);
      if (cur == 5'd2) m_idx <= 0;
      else if (cur != 5'd3) m_idx <= m_idx + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [4:0] s;
    logic [7:0] a;
    if (chk_on) begin
      s = m_seq[m_idx];
      a = alu_f(s == 5'd5 ? opcode[5:3] : 3'd0, rega, regb);
      chk("state", 8'(state), 8'(s));
      chk("cycle", 8'(cycle), 8'(m_idx));
      chk("pc", pc, m_pc);
      chk("sp", sp, m_sp);
      chk("alu_out", alu_out, a);
      chk("eq_zero", 8'(eq_zero), 8'(a == 0));
      chk("alu_equal", 8'(alu_equal), 8'(rega == regb));
      chk("jump_allowed", 8'(jump_allowed), 8'(jok(opcode[2:0], a == 0, rega == regb)));
      chk("halted", 8'(halted), 8'(s == 5'd3));
    end
  end

  initial begin
    logic [4:0] t1 [5];
    logic [7:0] o;
    int hc;
    t1 = '{5'd1, 5'd2, 5'd0, 5'd1, 5'd2};
    #2 chk_on = 1;
    repeat (2) step;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_cycle", 8'(cycle), 8'd0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_sp", sp, 8'hFF);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("nop_seq", 8'(state), 8'(t1[i]));
    end
    chk("nop_pc", pc, 8'h02);
    opcode = 8'h80; rega = 8'hFF; regb = 8'h01;
    repeat (3) step;
    chk("add_state", 8'(state), 8'd5);
    chk("add_out", alu_out, 8'h00);
    chk("add_z", 8'(eq_zero), 8'd1);
    step;
    opcode = 8'h88; rega = 8'h05; regb = 8'h05;
    #1 chk("sub_eq", 8'(alu_equal), 8'd1);
    repeat (3) step;
    chk("sub_out", alu_out, 8'h00);
    step;
    chk("alu_pc", pc, 8'h04);
    opcode = 8'hC1; bus_in = 8'h40; rega = 8'h10; regb = 8'hF0;
    repeat (4) step;
    chk("jz_state", 8'(state), 8'd6);
    chk("jz_ok", 8'(jump_allowed), 8'd1);
    step;
    chk("jz_pc", pc, 8'h40);
    rega = 8'h01; regb = 8'h01;
    repeat (4) step;
    chk("jz_no", 8'(jump_allowed), 8'd0);
    step;
    chk("jz_skip_pc", pc, 8'h42);
    opcode = 8'h03; bus_in = 8'h20;
    repeat (8) step;
    chk("call_state", 8'(state), 8'd2);
    chk("call_sp", sp, 8'hFE);
    chk("call_pc", pc, 8'h20);
    opcode = 8'h04; bus_in = 8'h55;
    repeat (6) step;
    chk("ret_sp", sp, 8'hFF);
    chk("ret_pc", pc, 8'h55);
    opcode = 8'h7A;
    repeat (5) step;
    chk("movm_state", 8'(state), 8'd10);
    chk("movm_pc", pc, 8'h57);
    step;
    opcode = 8'h4A;
    repeat (5) step;
    chk("mov_state", 8'(state), 8'd10);
    chk("mov_pc", pc, 8'h58);
    step;
    opcode = 8'h01;
    repeat (3) step;
    for (int i = 0; i < 10; i++) begin
      chk("hlt_state", 8'(state), 8'd3);
      chk("hlt_flag", 8'(halted), 8'd1);
      chk("hlt_pc", pc, 8'h59);
      step;
    end
    reset = 1;
    #2;
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_pc", pc, 8'h00);
    chk("arst_sp", sp, 8'hFF);
    step;
    reset = 0;
    hc = 0;
    repeat (3000) begin
      step;
      bus_in = 8'($urandom);
      rega = 8'($urandom);
      case ($urandom_range(0, 3))
        0: regb = rega;
        1: regb = 8'h00 - rega;
        default: regb = 8'($urandom);
      endcase
      if (m_seq[m_idx] == 5'd3) hc++;
      if (reset) reset = 0;
      else if (hc > 4 || $urandom_range(0, 199) == 0) begin
        reset = 1;
        hc = 0;
      end else if (m_seq[m_idx] == 5'd2) begin
        o = 8'($urandom);
        if (o == 8'h01) o = 8'h00;
        opcode = $urandom_range(0, 49) == 0 ? 8'h01 : o;
      end
    end
    step;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
